// File: rtl/lfsr_pulse_gen_if.sv
// Control/status bundle for lfsr_pulse_gen: step enable, divider, seed load and pulse outputs.
interface lfsr_pulse_gen_if #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8
);
    logic                 enable;
    logic [DIV_WIDTH-1:0] div;
    logic                 load;
    logic [WIDTH-1:0]     load_value;
    logic                 signal_out;
    logic                 step;
    logic                 signal_cycle;
    logic                 lockup;

    modport master (
        output enable, div, load, load_value,
        input  signal_out, step, signal_cycle, lockup
    );

    modport slave (
        input  enable, div, load, load_value,
        output signal_out, step, signal_cycle, lockup
    );
endinterface

// File: rtl/lfsr_pulse_gen.sv
// XNOR Fibonacci LFSR serial source with a programmable step divider, seed load and lock-up flag.
// Build option LFSR_LOCKUP_RECOVER_EN: reload SEED automatically when the all-ones state is reached.
module lfsr_pulse_gen #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int               DIV_WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    lfsr_pulse_gen_if.slave   bus
);

    logic [WIDTH-1:0]     lfsr, lfsr_d;
    logic [DIV_WIDTH-1:0] cnt, cnt_d;
    logic                 sig_q, sig_d;
    logic                 step_q, step_d;
    logic                 cyc_q, cyc_d;
    logic                 fb;
    logic [WIDTH-1:0]     lfsr_shift;

    assign fb         = ~^(lfsr & TAPS);
    assign lfsr_shift = {lfsr[WIDTH-2:0], fb};

    // Load outranks everything; enable low freezes the divider and the register.
    always_comb begin
        lfsr_d = lfsr;
        cnt_d  = cnt;
        sig_d  = sig_q;
        step_d = 1'b0;
        cyc_d  = 1'b0;
        if (bus.load) begin
            lfsr_d = bus.load_value;
            cnt_d  = '0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        end else if (bus.enable && (&lfsr)) begin
            lfsr_d = SEED;
            cnt_d  = '0;
`endif
        end else if (bus.enable) begin
            if (cnt >= bus.div) begin
                lfsr_d = lfsr_shift;
                sig_d  = lfsr[WIDTH-1];
                step_d = 1'b1;
                cyc_d  = (lfsr_shift == SEED);
                cnt_d  = '0;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr   <= SEED;
            cnt    <= '0;
            sig_q  <= 1'b0;
            step_q <= 1'b0;
            cyc_q  <= 1'b0;
        end else begin
            lfsr   <= lfsr_d;
            cnt    <= cnt_d;
            sig_q  <= sig_d;
            step_q <= step_d;
            cyc_q  <= cyc_d;
        end
    end

    // All-ones is the XNOR fixed point, so it is the only state worth flagging.
    assign bus.lockup       = &lfsr;
    assign bus.signal_out   = sig_q;
    assign bus.step         = step_q;
    assign bus.signal_cycle = cyc_q;

endmodule
